// File: rtl/vga_timing_pkg.sv
// Shared constants and pixel payload type for the VGA timing generator.
package vga_timing_pkg;

  // Counter and colour widths
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = 65535;
  localparam int unsigned COLOR_W = 8;

  // Default 640x480@60 timing
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam bit          DEF_SYNC_POL = 1'b0;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } vga_rgb_t;

  // Total period of one axis in counts
  function automatic int unsigned axis_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping counter plus active-region and sync-level flags.
// Region order along the axis is active, front porch, sync, back porch.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned FP       = DEF_H_FP,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BP       = DEF_H_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_c,
  output logic             active_c,
  output logic             sync_c
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  // Counter width is fixed; longer axes cannot be represented
  if (TOTAL > CNT_MAX) begin : g_total_check
    $error("vga_axis_counter: axis total %0d does not fit the %0d-bit counter", TOTAL, CNT_W);
  end

  logic [CNT_W-1:0] count_d, count_q;

  // Next count: advance when enabled, wrap at the end of the period
  always_comb begin
    wrap_c  = en_i && (count_q == CNT_W'(TOTAL - 1));
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_c ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Region decode from the current count; sync is returned at its line level
  always_comb begin
    active_c = count_q < CNT_W'(ACTIVE);
    sync_c   = !SYNC_POL;
    if ((count_q >= CNT_W'(SYNC_START)) && (count_q < CNT_W'(SYNC_END))) begin
      sync_c = SYNC_POL;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator and registered pixel output stage.
// Exports the raw h/v counters, samples same-cycle RGB from the pixel source
// and drives RGB/sync/blank one cycle after the coordinate they belong to.
// Optional colour-bar generator: define VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  input  logic               pattern_sel,
  output logic [CNT_W-1:0]   h_cont,
  output logic [CNT_W-1:0]   v_cont,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               vga_sync_n,
  output logic               frame_start
);

  logic h_wrap_c, h_active_c, h_sync_c;
  logic v_wrap_unused, v_active_c, v_sync_c;
  logic active_c;

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_cnt (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .en_i     (1'b1),
    .count_o  (h_cont),
    .wrap_c   (h_wrap_c),
    .active_c (h_active_c),
    .sync_c   (h_sync_c)
  );

  // Vertical axis steps once per line, on the horizontal wrap
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_cnt (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .en_i     (h_wrap_c),
    .count_o  (v_cont),
    .wrap_c   (v_wrap_unused),
    .active_c (v_active_c),
    .sync_c   (v_sync_c)
  );

  assign active_c = h_active_c && v_active_c;

  vga_rgb_t pix_in_c, pix_src_c;
  assign pix_in_c = '{r: red_in, g: green_in, b: blue_in};

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_idx_c;

  // Pixel source: eight vertical bars, index bits map to R/G/B
  always_comb begin
    bar_idx_c = 3'(h_cont / CNT_W'(BAR_W));
    pix_src_c = pix_in_c;
    if (pattern_sel) begin
      pix_src_c = '{r: {COLOR_W{bar_idx_c[2]}},
                    g: {COLOR_W{bar_idx_c[1]}},
                    b: {COLOR_W{bar_idx_c[0]}}};
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pix_src_c          = pix_in_c;
`endif

  vga_rgb_t rgb_d, rgb_q;
  logic     hs_d, hs_q, vs_d, vs_q, blank_n_d, blank_n_q;

  // Next output values: black outside the active area
  always_comb begin
    rgb_d     = '0;
    hs_d      = h_sync_c;
    vs_d      = v_sync_c;
    blank_n_d = active_c;
    if (active_c) begin
      rgb_d = pix_src_c;
    end
  end

  // Output register stage, one cycle behind the counters
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rgb_q     <= '0;
      hs_q      <= !SYNC_POL;
      vs_q      <= !SYNC_POL;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;

  // Counters sit at (0,0) throughout reset; qualify so the pulse stays low there
  assign frame_start = reset_reset_n && (h_cont == '0) && (v_cont == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen against a coordinate-arithmetic model,
// using a shrunken timing so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int unsigned VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam bit          SP = 1'b0;
  localparam int unsigned HT    = HA + HFP + HS + HBP;
  localparam int unsigned VT    = VA + VFP + VS + VBP;
  localparam int unsigned FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  red, green, blue;
  logic        sel;
  logic [15:0] h_cont, v_cont;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

  int unsigned n_vec, n_err;
  int unsigned t;
  logic [7:0]  prev_r, prev_g, prev_b;
`ifdef VGA_TEST_PATTERN_EN
  logic        prev_sel;
`endif
  int unsigned hs_cnt, vs_cnt, fs_cnt, fs_last;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_POL (SP)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .red_in        (red),
    .green_in      (green),
    .blue_in       (blue),
    .pattern_sel   (sel),
    .h_cont        (h_cont),
    .v_cont        (v_cont),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_blank_n   (vga_blank_n),
    .vga_sync_n    (vga_sync_n),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Expected pixel for coordinate (h,v) given the inputs presented there
  function automatic logic [23:0] model_rgb(input int unsigned h, input int unsigned v);
    int unsigned bar;
    bar = 0;
    if (!(h < HA && v < VA)) return 24'h0;
`ifdef VGA_TEST_PATTERN_EN
    if (prev_sel) begin
      bar = h / (HA / 8);
      return {((bar & 4) != 0) ? 8'hFF : 8'h00,
              ((bar & 2) != 0) ? 8'hFF : 8'h00,
              ((bar & 1) != 0) ? 8'hFF : 8'h00};
    end
`endif
    return {prev_r, prev_g, prev_b};
  endfunction

  function automatic logic in_range(input int unsigned x, input int unsigned lo, input int unsigned len);
    return (x >= lo) && (x < lo + len);
  endfunction

  // mode 0: random, 1: all 8'hFF, 2: all 8'hAB (pattern off)
  task automatic drive_inputs(input int mode);
    case (mode)
      1:       begin red = 8'hFF; green = 8'hFF; blue = 8'hFF; sel = 1'b0; end
      2:       begin red = 8'hAB; green = 8'hAB; blue = 8'hAB; sel = 1'b0; end
      default: begin
        red   = 8'($urandom);
        green = 8'($urandom);
        blue  = 8'($urandom);
        sel   = 1'($urandom_range(0, 1));
      end
    endcase
    prev_r = red; prev_g = green; prev_b = blue;
`ifdef VGA_TEST_PATTERN_EN
    prev_sel = sel;
`endif
  endtask

  task automatic check_reset();
    check_eq("rst_h_cont", 32'(h_cont), 0);
    check_eq("rst_v_cont", 32'(v_cont), 0);
    check_eq("rst_rgb", 32'({vga_r, vga_g, vga_b}), 0);
    check_eq("rst_hs", 32'(vga_hs), 32'(!SP));
    check_eq("rst_vs", 32'(vga_vs), 32'(!SP));
    check_eq("rst_blank_n", 32'(vga_blank_n), 0);
    check_eq("rst_sync_n", 32'(vga_sync_n), 0);
    check_eq("rst_frame_start", 32'(frame_start), 0);
  endtask

  // Compare everything visible at cycle t after reset release
  task automatic check_cycle();
    int unsigned eh, ev, ph, pv;
    logic [23:0] ergb;
    logic        ehs, evs, eblank;
    eh = t % HT;
    ev = (t / HT) % VT;
    check_eq("h_cont", 32'(h_cont), eh);
    check_eq("v_cont", 32'(v_cont), ev);
    if (t == 0) begin
      ergb = 24'h0; ehs = !SP; evs = !SP; eblank = 1'b0;
    end else begin
      ph     = (t - 1) % HT;
      pv     = ((t - 1) / HT) % VT;
      ergb   = model_rgb(ph, pv);
      ehs    = in_range(ph, HA + HFP, HS) ? SP : !SP;
      evs    = in_range(pv, VA + VFP, VS) ? SP : !SP;
      eblank = (ph < HA) && (pv < VA);
    end
    check_eq("rgb", 32'({vga_r, vga_g, vga_b}), 32'(ergb));
    check_eq("hs", 32'(vga_hs), 32'(ehs));
    check_eq("vs", 32'(vga_vs), 32'(evs));
    check_eq("blank_n", 32'(vga_blank_n), 32'(eblank));
    check_eq("sync_n", 32'(vga_sync_n), 0);
    check_eq("frame_start", 32'(frame_start), 32'(eh == 0 && ev == 0));
    if (t >= 1 && t <= HT && vga_hs == SP) hs_cnt++;
    if (t == HT) check_eq("hsync_width", hs_cnt, HS);
    if (t >= 1 && t <= FRAME && vga_vs == SP) vs_cnt++;
    if (t == FRAME) check_eq("vsync_width", vs_cnt, VS * HT);
    if (frame_start) begin
      if (fs_cnt > 0) check_eq("frame_period", t - fs_last, FRAME);
      fs_last = t;
      fs_cnt++;
    end
  endtask

  task automatic release_reset(input int mode);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_last = 0;
    #1;
    check_cycle();
    drive_inputs(mode);
  endtask

  task automatic run(input int unsigned n, input int mode);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      t++;
      check_cycle();
      drive_inputs(mode);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_inputs(1);
    #1;
    check_reset();
    @(posedge clk);
    #1;
    check_reset();
  endtask

  initial begin
    n_vec = 0; n_err = 0; t = 0;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_last = 0;
    drive_inputs(1);
    repeat (3) @(negedge clk);
    #1;
    check_reset();

    // First frames: white first pixel, then random pixels/pattern select
    release_reset(1);
    run(3, 1);
    run(2 * FRAME + 7, 0);
    check_eq("frame_pulses", fs_cnt, 3);

    // Reset asserted mid-line, then a constant-colour frame for blanking
    run(7, 0);
    mid_reset();
    release_reset(1);
    run(2, 1);
    run(FRAME + 5, 2);
    check_eq("frame_pulses_2", fs_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
